// File: rtl/fertilising_pkg.sv
// Shared definitions for the multi-zone fertilising controller.
// Holds the controller state encoding and the default parameter values
// used by the top level.
package fertilising_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DOSE  = 2'd1,
        ST_CLEAN = 2'd2
    } state_t;

    localparam int DEF_ZONES      = 4;
    localparam int DEF_DOSE_TICKS = 10;
    localparam int DEF_TIMER_W    = 8;
    localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/round_robin_arbiter.sv
// Purely combinational round-robin arbiter.
// Picks the first asserted request at or after ptr, wrapping past N-1 to 0.
// Ports:
//   req        in   N       request vector
//   ptr        in   IDX_W   index with highest priority this cycle
//   grant      out  N       one-hot grant (all zero when no request)
//   grant_idx  out  IDX_W   index of the granted request
//   valid      out  1       at least one request present
module round_robin_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    int idx;

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/multi_zone_fertilising_controller.sv
// Shared-tank fertiliser injector serving ZONES zones through one pump.
// Captures per-zone requests (rising edge of fertilise_push), rejects unsafe
// ones with a sticky alarm, grants zones round-robin, meters each dose for
// DOSE_TICKS tick strobes and runs a tank-cleaning cycle at critical level.
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   tick               one-cycle timebase strobe
//   critical_level     tank at critical level
//   empty_tank         tank empty
//   sprinkler[ZONES]   zone sprinkler running
//   fertilise_push[ZONES] zone request level
//   alarm_clear        clears all alarm bits
//   fertilising[ZONES] injector open to zone (one-hot or zero)
//   cleaning           tank cleaning valve open
//   alarm[ZONES]       sticky rejected/aborted flags
//   busy               controller not idle
//   dose_count[CNT_W]  completed doses, saturating
module multi_zone_fertilising_controller
    import fertilising_pkg::*;
#(
    parameter int ZONES      = DEF_ZONES,
    parameter int DOSE_TICKS = DEF_DOSE_TICKS,
    parameter int TIMER_W    = DEF_TIMER_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             critical_level,
    input  logic             empty_tank,
    input  logic [ZONES-1:0] sprinkler,
    input  logic [ZONES-1:0] fertilise_push,
    input  logic             alarm_clear,
    output logic [ZONES-1:0] fertilising,
    output logic             cleaning,
    output logic [ZONES-1:0] alarm,
    output logic             busy,
    output logic [CNT_W-1:0] dose_count
);

    localparam int IDX_W = $clog2(ZONES);

    state_t             state, state_next;
    logic [ZONES-1:0]   push_q, pending;
    logic [ZONES-1:0]   push_edge, occupied, accept, reject;
    logic [ZONES-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx, ptr, cur_zone;
    logic               arb_valid;
    logic [TIMER_W-1:0] timer;
    logic               do_grant, do_abort, do_finish;

    // A zone already waiting or being dosed ignores further pushes silently.
    assign push_edge = fertilise_push & ~push_q;
    assign occupied  = pending | fertilising;
    assign accept    = push_edge & ~occupied & sprinkler & {ZONES{~critical_level}};
    assign reject    = push_edge & ~occupied & (~sprinkler | {ZONES{critical_level}});

    round_robin_arbiter #(.N(ZONES)) u_arbiter (
        .req       (pending),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_abort   = 1'b0;
        do_finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (critical_level && !empty_tank) begin
                    state_next = ST_CLEAN;
                end else if (arb_valid) begin
                    do_grant   = 1'b1;
                    state_next = ST_DOSE;
                end
            end
            ST_DOSE: begin
                // Safety abort outranks a tick arriving in the same cycle.
                if (critical_level || !sprinkler[cur_zone]) begin
                    do_abort   = 1'b1;
                    state_next = (critical_level && !empty_tank) ? ST_CLEAN : ST_IDLE;
                end else if (tick && timer == TIMER_W'(1)) begin
                    do_finish  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAN: begin
                if (empty_tank || !critical_level) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            push_q      <= '0;
            pending     <= '0;
            alarm       <= '0;
            fertilising <= '0;
            cleaning    <= 1'b0;
            busy        <= 1'b0;
            dose_count  <= '0;
            ptr         <= '0;
            cur_zone    <= '0;
            timer       <= '0;
        end else begin
            push_q   <= fertilise_push;
            pending  <= (pending | accept) & ~(do_grant ? arb_grant : '0);
            // A new rejection or abort in the same cycle as alarm_clear survives.
            alarm    <= (alarm & ~{ZONES{alarm_clear}}) | reject
                        | (do_abort ? fertilising : '0);
            cleaning <= (state_next == ST_CLEAN);
            busy     <= (state_next != ST_IDLE);

            if (do_grant) begin
                cur_zone    <= arb_idx;
                ptr         <= (arb_idx == IDX_W'(ZONES - 1)) ? '0 : arb_idx + IDX_W'(1);
                timer       <= TIMER_W'(DOSE_TICKS);
                fertilising <= arb_grant;
            end else if (do_abort) begin
                fertilising <= '0;
            end else if (state == ST_DOSE && tick) begin
                timer <= timer - TIMER_W'(1);
                if (do_finish) begin
                    fertilising <= '0;
                    if (dose_count != '1) begin
                        dose_count <= dose_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_zone_fertilising_controller.sv
// Directed bench for multi_zone_fertilising_controller (ZONES=4, DOSE_TICKS=3).
module tb_multi_zone_fertilising_controller;

    localparam int ZONES = 4;
    localparam int DOSE_TICKS = 3;
    localparam int TIMER_W = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             tick = 1'b0;
    logic             critical_level = 1'b0;
    logic             empty_tank = 1'b0;
    logic [ZONES-1:0] sprinkler = '0;
    logic [ZONES-1:0] fertilise_push = '0;
    logic             alarm_clear = 1'b0;
    logic [ZONES-1:0] fertilising;
    logic             cleaning;
    logic [ZONES-1:0] alarm;
    logic             busy;
    logic [CNT_W-1:0] dose_count;

    int n_checks = 0;
    int n_fail = 0;

    multi_zone_fertilising_controller #(
        .ZONES(ZONES), .DOSE_TICKS(DOSE_TICKS), .TIMER_W(TIMER_W), .CNT_W(CNT_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .tick           (tick),
        .critical_level (critical_level),
        .empty_tank     (empty_tank),
        .sprinkler      (sprinkler),
        .fertilise_push (fertilise_push),
        .alarm_clear    (alarm_clear),
        .fertilising    (fertilising),
        .cleaning       (cleaning),
        .alarm          (alarm),
        .busy           (busy),
        .dose_count     (dose_count)
    );

    always #5 clock = ~clock;

    // Structural invariants sampled on every falling edge out of reset.
    always @(negedge clock) begin
        if (reset_n) begin
            n_checks++;
            if (!$onehot0(fertilising) || (|fertilising && cleaning)) begin
                n_fail++;
                $display("FAIL invariant: fertilising=%b cleaning=%b", fertilising, cleaning);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({fertilising, cleaning, alarm, busy, dose_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got f=%b c=%b a=%b b=%b n=%0d required all zero",
                     fertilising, cleaning, alarm, busy, dose_count);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_dose();
        sprinkler = 4'b0001;
        fertilise_push = 4'b0001;
        step();
        n_checks++;
        if (fertilising !== 4'b0000) begin
            n_fail++; $display("FAIL t1_latency1: fertilising=%b required 0000", fertilising);
        end
        step();
        n_checks++;
        if (fertilising !== 4'b0001 || busy !== 1'b1) begin
            n_fail++; $display("FAIL t1_grant: fertilising=%b busy=%b required 0001/1", fertilising, busy);
        end
        pulse_tick();
        pulse_tick();
        n_checks++;
        if (fertilising !== 4'b0001) begin
            n_fail++; $display("FAIL t1_two_ticks: fertilising=%b required 0001", fertilising);
        end
        pulse_tick();
        n_checks++;
        if (fertilising !== 4'b0000 || dose_count !== 4'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t1_done: f=%b n=%0d busy=%b required 0000/1/0", fertilising, dose_count, busy);
        end
    endtask

    task automatic test_round_robin();
        sprinkler = 4'b1111;
        fertilise_push = 4'b0000;
        step();
        fertilise_push = 4'b1110;
        step();
        step();
        n_checks++;
        if (fertilising !== 4'b0010) begin
            n_fail++; $display("FAIL t2_first: fertilising=%b required 0010", fertilising);
        end
        repeat (DOSE_TICKS) pulse_tick();
        n_checks++;
        if (fertilising !== 4'b0000) begin
            n_fail++; $display("FAIL t2_gap1: fertilising=%b required 0000", fertilising);
        end
        step();
        n_checks++;
        if (fertilising !== 4'b0100) begin
            n_fail++; $display("FAIL t2_second: fertilising=%b required 0100", fertilising);
        end
        repeat (DOSE_TICKS) pulse_tick();
        step();
        n_checks++;
        if (fertilising !== 4'b1000) begin
            n_fail++; $display("FAIL t2_third: fertilising=%b required 1000", fertilising);
        end
        repeat (DOSE_TICKS) pulse_tick();
        n_checks++;
        if (dose_count !== 4'd4) begin
            n_fail++; $display("FAIL t2_count: dose_count=%0d required 4", dose_count);
        end
        // Pointer now wraps to 0: zone 0 must win over zone 3.
        fertilise_push = 4'b0000;
        step();
        fertilise_push = 4'b1001;
        step();
        step();
        n_checks++;
        if (fertilising !== 4'b0001) begin
            n_fail++; $display("FAIL t2_wrap: fertilising=%b required 0001", fertilising);
        end
        repeat (DOSE_TICKS) pulse_tick();
        step();
        n_checks++;
        if (fertilising !== 4'b1000) begin
            n_fail++; $display("FAIL t2_wrap_next: fertilising=%b required 1000", fertilising);
        end
        repeat (DOSE_TICKS) pulse_tick();
        n_checks++;
        if (dose_count !== 4'd6) begin
            n_fail++; $display("FAIL t2_count_end: dose_count=%0d required 6", dose_count);
        end
    endtask

    task automatic test_alarm();
        fertilise_push = 4'b0000;
        sprinkler = 4'b1011;
        step();
        fertilise_push = 4'b0100;
        step();
        n_checks++;
        if (alarm !== 4'b0100) begin
            n_fail++; $display("FAIL t3_reject: alarm=%b required 0100", alarm);
        end
        step();
        n_checks++;
        if (fertilising !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t3_no_dose: f=%b busy=%b required 0000/0", fertilising, busy);
        end
        fertilise_push = 4'b0000;
        step();
        alarm_clear = 1'b1;
        fertilise_push = 4'b0100;
        step();
        n_checks++;
        if (alarm !== 4'b0100) begin
            n_fail++; $display("FAIL t3_set_wins: alarm=%b required 0100", alarm);
        end
        fertilise_push = 4'b0000;
        step();
        n_checks++;
        if (alarm !== 4'b0000) begin
            n_fail++; $display("FAIL t3_clear: alarm=%b required 0000", alarm);
        end
        alarm_clear = 1'b0;
    endtask

    task automatic test_abort_clean();
        sprinkler = 4'b0001;
        fertilise_push = 4'b0001;
        step();
        step();
        n_checks++;
        if (fertilising !== 4'b0001) begin
            n_fail++; $display("FAIL t4_grant: fertilising=%b required 0001", fertilising);
        end
        pulse_tick();
        critical_level = 1'b1;
        empty_tank = 1'b0;
        step();
        n_checks++;
        if (fertilising !== 4'b0000 || alarm !== 4'b0001 || cleaning !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL t4_abort: f=%b a=%b c=%b b=%b required 0000/0001/1/1",
                               fertilising, alarm, cleaning, busy);
        end
        empty_tank = 1'b1;
        step();
        n_checks++;
        if (cleaning !== 1'b0 || busy !== 1'b0 || dose_count !== 4'd6) begin
            n_fail++; $display("FAIL t4_clean_exit: c=%b b=%b n=%0d required 0/0/6", cleaning, busy, dose_count);
        end
        critical_level = 1'b0;
        empty_tank = 1'b0;
        alarm_clear = 1'b1;
        fertilise_push = 4'b0000;
        step();
        alarm_clear = 1'b0;
        step();
    endtask

    task automatic test_pending_through_clean();
        sprinkler = 4'b0111;
        fertilise_push = 4'b0001;
        step();
        step();
        fertilise_push = 4'b0011;
        step();
        n_checks++;
        if (fertilising !== 4'b0001) begin
            n_fail++; $display("FAIL t5_dosing0: fertilising=%b required 0001", fertilising);
        end
        critical_level = 1'b1;
        step();
        n_checks++;
        if (fertilising !== 4'b0000 || cleaning !== 1'b1 || alarm !== 4'b0001) begin
            n_fail++; $display("FAIL t5_to_clean: f=%b c=%b a=%b required 0000/1/0001", fertilising, cleaning, alarm);
        end
        fertilise_push = 4'b0111;
        step();
        n_checks++;
        if (alarm !== 4'b0101 || cleaning !== 1'b1) begin
            n_fail++; $display("FAIL t5_crit_reject: a=%b c=%b required 0101/1", alarm, cleaning);
        end
        step();
        n_checks++;
        if (fertilising !== 4'b0000) begin
            n_fail++; $display("FAIL t5_held: fertilising=%b required 0000", fertilising);
        end
        critical_level = 1'b0;
        step();
        n_checks++;
        if (cleaning !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_exit: c=%b busy=%b required 0/0", cleaning, busy);
        end
        step();
        n_checks++;
        if (fertilising !== 4'b0010) begin
            n_fail++; $display("FAIL t5_dispatch: fertilising=%b required 0010", fertilising);
        end
        repeat (DOSE_TICKS) pulse_tick();
        n_checks++;
        if (fertilising !== 4'b0000 || dose_count !== 4'd7) begin
            n_fail++; $display("FAIL t5_done: f=%b n=%0d required 0000/7", fertilising, dose_count);
        end
    endtask

    task automatic test_async_reset_and_saturation();
        fertilise_push = 4'b0000;
        sprinkler = 4'b0001;
        step();
        fertilise_push = 4'b0001;
        step();
        step();
        n_checks++;
        if (fertilising !== 4'b0001) begin
            n_fail++; $display("FAIL t6_grant: fertilising=%b required 0001", fertilising);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (fertilising !== 4'b0000 || busy !== 1'b0 || alarm !== 4'b0000 || dose_count !== 4'd0) begin
            n_fail++; $display("FAIL t6_async_reset: f=%b b=%b a=%b n=%0d required all zero",
                               fertilising, busy, alarm, dose_count);
        end
        #2;
        fertilise_push = 4'b0000;
        reset_n = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            fertilise_push = 4'b0000;
            step();
            fertilise_push = 4'b0001;
            step();
            step();
            repeat (DOSE_TICKS) pulse_tick();
            if (i == (1 << CNT_W) - 2) begin
                n_checks++;
                if (dose_count !== CNT_W'((1 << CNT_W) - 1)) begin
                    n_fail++; $display("FAIL t6_reach_max: dose_count=%0d required %0d", dose_count, (1 << CNT_W) - 1);
                end
            end
        end
        n_checks++;
        if (dose_count !== CNT_W'((1 << CNT_W) - 1)) begin
            n_fail++; $display("FAIL t6_saturate: dose_count=%0d required %0d", dose_count, (1 << CNT_W) - 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_dose();
        test_round_robin();
        test_alarm();
        test_abort_clean();
        test_pending_through_clean();
        test_async_reset_and_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
